// File: rtl/arb8_rr.sv
// 8-way round-robin arbiter with a bounded grant length.
// The grant is released on !req[sel], done[sel] or timeout, and every release is followed by one dead cycle.
module arb8_rr #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] done,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       timeout_err
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_sel;
  logic [7:0] r_gnt;
  logic [7:0] r_cnt;
  logic       r_valid;
  logic       r_terr;

  logic       w_found;
  logic [2:0] w_idx;
  logic       w_tmo;
  logic       w_rel;

  // The first set request found from r_ptr upward, with wrap-around.
  always_comb begin
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int i = 0; i < 8; i++) begin
      if (!w_found && req[r_ptr + 3'(i)]) begin
        w_found = 1'b1;
        w_idx   = r_ptr + 3'(i);
      end
    end
  end

  assign w_tmo = (r_cnt == CNT_MAX);
  assign w_rel = !req[r_sel] || done[r_sel] || w_tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= 3'd0;
      r_sel   <= 3'd0;
      r_gnt   <= 8'd0;
      r_cnt   <= 8'd0;
      r_valid <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_terr <= 1'b0;
          // With no request, sel keeps its value so the datapath mux output stays stable.
          if (w_found) begin
            r_state <= GRANT;
            r_sel   <= w_idx;
            r_gnt   <= 8'd1 << w_idx;
            r_valid <= 1'b1;
            r_cnt   <= 8'd0;
          end
        end
        GRANT: begin
          if (w_rel) begin
            r_state <= IDLE;
            r_gnt   <= 8'd0;
            r_valid <= 1'b0;
            r_cnt   <= 8'd0;
            r_ptr   <= r_sel + 3'd1;
            // The error is flagged only when the release was forced by the timeout alone.
            r_terr  <= w_tmo && req[r_sel] && !done[r_sel];
          end else begin
            r_cnt   <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sel         = r_sel;
  assign gnt         = r_gnt;
  assign valid       = r_valid;
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_arb8_rr.sv
// Bench for arb8_rr (TIMEOUT=4). It runs a vector table, hand-written reset/rotation sequences,
// and randomized traffic checked against a reference model.
module tb_arb8_rr;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req, done;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  arb8_rr #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .sel(sel), .gnt(gnt), .valid(valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       v;
    logic       te;
  } vec_t;

  vec_t tbl[22];

  // Reference model state: owner < 0 means no grant.
  // last is the most recently released index, and the search starts at last+1.
  int m_owner, m_held, m_last, m_sel;
  bit m_te;

  task automatic check(input string name, input logic [2:0] s, input logic [7:0] g,
                       input logic v, input logic te);
    n_cmp++;
    if ({sel, gnt, valid, timeout_err} !== {s, g, v, te}) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d gnt=%02h valid=%b terr=%b, want sel=%0d gnt=%02h valid=%b terr=%b",
               name, sel, gnt, valid, timeout_err, s, g, v, te);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    check("reset_state", 3'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = 7; m_sel = 0; m_te = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] d);
    if (m_owner < 0) begin
      m_te = 0;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_last + 1 + k) % 8;
        if (r[idx]) begin
          m_owner = idx; m_sel = idx; m_held = 0;
          break;
        end
      end
    end else if (!r[m_owner] || d[m_owner]) begin
      m_te = 0; m_last = m_owner; m_owner = -1;
    end else if (m_held == TO - 1) begin
      m_te = 1; m_last = m_owner; m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  initial begin
    reset = 1'b1; req = 8'h00; done = 8'h00;

    // Fields: req, done -> expected gnt, sel, valid, timeout_err after the edge.
    tbl[0]  = '{8'h24, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[1]  = '{8'h24, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0};
    tbl[2]  = '{8'h24, 8'h00, 8'h20, 3'd5, 1'b1, 1'b0};
    tbl[3]  = '{8'h20, 8'h20, 8'h00, 3'd5, 1'b0, 1'b0};
    tbl[4]  = '{8'h40, 8'h00, 8'h40, 3'd6, 1'b1, 1'b0};
    tbl[5]  = '{8'h40, 8'h40, 8'h00, 3'd6, 1'b0, 1'b0};
    tbl[6]  = '{8'h81, 8'h00, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[7]  = '{8'h81, 8'h80, 8'h00, 3'd7, 1'b0, 1'b0};
    tbl[8]  = '{8'h81, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[9]  = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[12] = '{8'h08, 8'hF7, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[13] = '{8'h0C, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[14] = '{8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[15] = '{8'h08, 8'h00, 8'h00, 3'd3, 1'b0, 1'b1};
    tbl[16] = '{8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[17] = '{8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[18] = '{8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[19] = '{8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0};
    tbl[20] = '{8'h08, 8'h08, 8'h00, 3'd3, 1'b0, 1'b0};
    tbl[21] = '{8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0};

    #2;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].req, tbl[i].done);
      check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].v, tbl[i].te);
    end

    // All requesting, each owner releases after one cycle: 0..7,0 with one dead cycle between grants.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << (k % 8);
      step(8'hFF, 8'h00);
      check($sformatf("rot_gnt%0d", k), 3'(k % 8), oh, 1'b1, 1'b0);
      step(8'hFF, oh);
      check($sformatf("rot_dead%0d", k), 3'(k % 8), 8'h00, 1'b0, 1'b0);
    end

    // An async reset in the middle of grant 5 clears the outputs before the next edge,
    // and the search afterwards restarts from index 0.
    do_reset();
    step(8'h01, 8'h00);
    step(8'h01, 8'h01);
    step(8'h20, 8'h00);
    check("pre_rst_gnt5", 3'd5, 8'h20, 1'b1, 1'b0);
    step(8'h20, 8'h00);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst", 3'd0, 8'h00, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_gnt5", 3'd5, 8'h20, 1'b1, 1'b0);

    // Randomized traffic against the reference model, with occasional async resets.
    do_reset();
    model_reset();
    req = 8'h00;
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] r, d;
      r = ($urandom_range(0, 5) == 0) ? 8'($urandom) : req;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(r, d);
      model_step(r, d);
      check("rand", 3'(m_sel), (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00,
            m_owner >= 0, m_te);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        check("rand_rst", 3'd0, 8'h00, 1'b0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
